// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master engine between NUM_REQ requesters.
// One register transaction in flight at a time: accept, launch, wait for done/timeout, respond.
module i2c_txn_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic [1:0]           grant_id,
  output logic                 m_start,
  output logic                 m_rw,
  output logic [6:0]           m_dev_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_wdata,
  output logic                 m_abort,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [TO_W-1:0] to_cnt;

  logic [3:0] valid_pad;
  logic [3:0] rw_pad;
  logic [6:0] dev_arr [4];
  logic [7:0] reg_arr [4];
  logic [7:0] wd_arr  [4];

  logic       win_found;
  logic [1:0] win_idx;
  logic [2:0] scan_pos;

  // Widen the per-requester buses to four lanes so a 2-bit index can select any of them.
  always_comb begin
    valid_pad = 4'(req_valid);
    rw_pad    = 4'(req_rw);
    for (int i = 0; i < 4; i++) begin
      dev_arr[i] = '0;
      reg_arr[i] = '0;
      wd_arr[i]  = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      dev_arr[i] = req_dev_addr[7*i +: 7];
      reg_arr[i] = req_reg_addr[8*i +: 8];
      wd_arr[i]  = req_wdata[8*i +: 8];
    end
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_pos = {1'b0, rr_ptr} + 3'(k);
      if (scan_pos >= 3'(NUM_REQ)) scan_pos = scan_pos - 3'(NUM_REQ);
      if (!win_found && valid_pad[scan_pos[1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_pos[1:0];
      end
    end
  end

  // Accept is a same-cycle handshake; gating on rst keeps it quiet while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = rst && (state == IDLE) && win_found && (win_idx == 2'(i));
  end

  // NOTE: sequential state uses non-blocking assignments only; the pulse defaults at the top
  // are overridden later in the same block, which is well defined for <=.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here, including the held address/data, is cleared by the async reset.
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      to_cnt     <= '0;
      grant_id   <= '0;
      m_start    <= 1'b0;
      m_abort    <= 1'b0;
      m_rw       <= 1'b0;
      m_dev_addr <= '0;
      m_reg_addr <= '0;
      m_wdata    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      m_start   <= 1'b0;
      m_abort   <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant_id   <= win_idx;
            rr_ptr     <= (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
            m_rw       <= rw_pad[win_idx];
            m_dev_addr <= dev_arr[win_idx];
            m_reg_addr <= reg_arr[win_idx];
            m_wdata    <= wd_arr[win_idx];
            to_cnt     <= '0;
            m_start    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt <= to_cnt + 1'b1;
          state  <= WAIT;
        end
        WAIT: begin
          // to_cnt counts cycles since m_start; a done in the last allowed cycle beats the timeout.
          if (m_done) begin
            for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (grant_id == 2'(i));
            rsp_err   <= m_nack ? ERR_NACK : ERR_OK;
            rsp_rdata <= (m_rw && !m_nack) ? m_rdata : 8'h00;
            state     <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 2)) begin
            for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (grant_id == 2'(i));
            rsp_err   <= ERR_TIMEOUT;
            rsp_rdata <= 8'h00;
            m_abort   <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a timeline model of the arbitration and response rules.
module tb_i2c_txn_arbiter;

  localparam int N  = 3;
  localparam int T  = 16;
  localparam int DW = 7 * N;
  localparam int BW = 8 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid, req_ready, req_rw, rsp_valid;
  logic [DW-1:0] req_dev_addr;
  logic [BW-1:0] req_reg_addr, req_wdata;
  logic [7:0]    rsp_rdata;
  logic [1:0]    rsp_err, grant_id;
  logic          m_start, m_rw, m_abort, m_done, m_nack;
  logic [6:0]    m_dev_addr;
  logic [7:0]    m_reg_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic       rw_tab  [N];
  logic [6:0] dev_tab [N];
  logic [7:0] reg_tab [N];
  logic [7:0] wd_tab  [N];

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T), .TO_W(11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant_id(grant_id),
    .m_start(m_start), .m_rw(m_rw), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: transaction timeline per accept ----------------
  int         cyc = 0;
  bit         busy = 0, have_rsp = 0, was_to = 0;
  int         acc = 0, rsp_cyc = 0, owner = 0, ptr = 0;
  logic       t_rw = 1'b0, e_rw = 1'b0;
  logic [6:0] e_dev = '0;
  logic [7:0] e_reg = '0, e_wd = '0, e_rd = '0;
  logic [1:0] e_err = '0, e_gid = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_rv;
    int           win, idx;
    bit           e_rsp;
    cyc++;
    if (!rst) begin
      busy = 0; have_rsp = 0; ptr = 0;
      e_rw = 1'b0; e_dev = '0; e_reg = '0; e_wd = '0; e_gid = '0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_m_start",   32'(m_start),   32'd0);
      check("rst_m_abort",   32'(m_abort),   32'd0);
      check("rst_grant_id",  32'(grant_id),  32'd0);
      check("rst_m_fields",  {8'h0, m_rw, m_dev_addr, m_reg_addr, m_wdata}, 32'd0);
      check("rst_rsp_data",  {22'h0, rsp_err, rsp_rdata}, 32'd0);
    end else begin
      if (busy && have_rsp && cyc > rsp_cyc) busy = 0;
      e_ready = '0;
      win = 0;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (e_ready == '0 && 1'(req_valid >> idx)) begin
            win = idx;
            e_ready = N'(1) << idx;
          end
        end
      end
      if (busy && !have_rsp) begin
        if (m_done && cyc >= acc + 2 && cyc <= acc + T - 1) begin
          have_rsp = 1; was_to = 0; rsp_cyc = cyc + 1;
          e_err = m_nack ? 2'd1 : 2'd0;
          e_rd  = (!m_nack && t_rw) ? m_rdata : 8'h00;
        end else if (cyc == acc + T - 1) begin
          have_rsp = 1; was_to = 1; rsp_cyc = acc + T;
          e_err = 2'd2;
          e_rd  = 8'h00;
        end
      end
      e_rsp = busy && have_rsp && (cyc == rsp_cyc);
      e_rv  = e_rsp ? (N'(1) << owner) : '0;
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("m_start",   32'(m_start),   32'(busy && cyc == acc + 1));
      check("m_abort",   32'(m_abort),   32'(e_rsp && was_to));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rsp) begin
        check("rsp_err",   32'(rsp_err),   32'(e_err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
      end
      check("grant_id", 32'(grant_id), 32'(e_gid));
      check("m_fields", {8'h0, m_rw, m_dev_addr, m_reg_addr, m_wdata},
                        {8'h0, e_rw, e_dev, e_reg, e_wd});
      if (e_ready != '0) begin
        busy = 1; have_rsp = 0; acc = cyc; owner = win;
        ptr   = (win + 1) % N;
        t_rw  = 1'(req_rw >> win);
        e_rw  = t_rw;
        e_dev = 7'(req_dev_addr >> (7 * win));
        e_reg = 8'(req_reg_addr >> (8 * win));
        e_wd  = 8'(req_wdata >> (8 * win));
        e_gid = 2'(win);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd);
    rw_tab[i] = rw; dev_tab[i] = dev; reg_tab[i] = ra; wd_tab[i] = wd;
    req_rw[i] = rw;
    req_dev_addr[7*i +: 7] = dev;
    req_reg_addr[8*i +: 8] = ra;
    req_wdata[8*i +: 8]    = wd;
  endtask

  task automatic wait_ready(output int w);
    w = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (1'(req_ready >> i)) w = i;
        break;
      end
    end
    if (w < 0) begin
      n_cmp++; n_err++;
      $display("FAIL ready_wait: no req_ready within 50 cycles, want one");
    end
  endtask

  // Accept, check launch fields, answer with m_done two cycles after accept, check response.
  task automatic do_txn(input int exp_w, input bit drop, input logic nack, input logic [7:0] rd,
                        input logic [1:0] exp_err, input logic [7:0] exp_rd);
    int w;
    wait_ready(w);
    check("winner", 32'(w), 32'(exp_w));
    @(posedge clk); #1;
    if (drop) req_valid = req_valid & ~(N'(1) << exp_w);
    @(negedge clk);
    check("dir_m_start", 32'(m_start), 32'd1);
    check("dir_grant",   32'(grant_id), 32'(exp_w));
    check("dir_fields", {8'h0, m_rw, m_dev_addr, m_reg_addr, m_wdata},
                        {8'h0, rw_tab[exp_w], dev_tab[exp_w], reg_tab[exp_w], wd_tab[exp_w]});
    @(posedge clk); #1;
    m_done = 1'b1; m_nack = nack; m_rdata = rd;
    @(posedge clk); #1;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    @(negedge clk);
    check("dir_rsp_valid", 32'(rsp_valid), 32'(N'(1) << exp_w));
    check("dir_rsp_err",   32'(rsp_err),   32'(exp_err));
    check("dir_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
  endtask

  initial begin
    int w, s, ab;
    req_valid = '0; req_rw = '0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single write from req0
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    req_valid = 3'b001;
    do_txn(0, 1, 1'b0, 8'h99, 2'd0, 8'h00);

    // single read from req1
    @(posedge clk); #1;
    set_req(1, 1'b1, 7'h68, 8'h75, 8'h00);
    req_valid = 3'b010;
    do_txn(1, 1, 1'b0, 8'h3C, 2'd0, 8'h3C);

    // round robin with req0 and req1 both held
    @(posedge clk); #1;
    set_req(0, 1'b0, 7'h11, 8'h22, 8'h33);
    set_req(1, 1'b0, 7'h44, 8'h55, 8'h66);
    req_valid = 3'b011;
    do_txn(0, 0, 1'b0, 8'h00, 2'd0, 8'h00);
    do_txn(1, 0, 1'b0, 8'h00, 2'd0, 8'h00);
    do_txn(0, 0, 1'b0, 8'h00, 2'd0, 8'h00);
    do_txn(1, 0, 1'b0, 8'h00, 2'd0, 8'h00);
    @(posedge clk); #1 req_valid = '0;

    // NACK on a read from req2
    set_req(2, 1'b1, 7'h3A, 8'h01, 8'h00);
    req_valid = 3'b100;
    do_txn(2, 1, 1'b1, 8'h77, 2'd1, 8'h00);

    // timeout on req0, then req1 served normally
    @(posedge clk); #1;
    set_req(0, 1'b0, 7'h22, 8'h33, 8'h44);
    req_valid = 3'b001;
    wait_ready(w);
    check("to_winner", 32'(w), 32'd0);
    @(posedge clk); #1 req_valid = '0;
    s = -100; ab = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_start) s = k;
      if (m_abort) begin
        ab = k;
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err",   32'(rsp_err),   32'd2);
        check("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
        break;
      end
    end
    check("abort_offset", 32'(ab - s), 32'd15);
    @(posedge clk); #1;
    set_req(1, 1'b1, 7'h0F, 8'hF0, 8'h00);
    req_valid = 3'b010;
    do_txn(1, 1, 1'b0, 8'h5A, 2'd0, 8'h5A);

    // reset in the middle of WAIT; afterwards arbitration restarts from requester 0
    @(posedge clk); #1;
    set_req(2, 1'b0, 7'h7F, 8'hAA, 8'hBB);
    req_valid = 3'b100;
    wait_ready(w);
    check("rw_winner", 32'(w), 32'd2);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {23'h0, rsp_valid, m_start, m_abort, grant_id, m_rw}, 32'd0);
    check("mid_rst_dev", 32'(m_dev_addr), 32'd0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    set_req(1, 1'b0, 7'h12, 8'h34, 8'h56);
    req_valid = 3'b110;
    do_txn(1, 1, 1'b0, 8'h00, 2'd0, 8'h00);
    @(posedge clk); #1 req_valid = '0;

    // random traffic, including spurious m_done and occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 599) != 0);
      req_valid    = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
      req_rw       = N'($urandom);
      req_dev_addr = DW'($urandom);
      req_reg_addr = BW'($urandom);
      req_wdata    = BW'($urandom);
      m_done       = ($urandom_range(0, 9) == 0);
      m_nack       = ($urandom_range(0, 3) == 0);
      m_rdata      = 8'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; m_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
